// File: rtl/ld_str_mem_unit_pkg.sv
// Shared types and constants for the load/store memory unit.
//   lc3b_word    : 16-bit machine word
//   lsu_state_e  : handshake FSM states
//   BE_*         : cache byte-enable encodings
package ld_str_mem_unit_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int TAG_WIDTH  = 3;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_LO   = 2'b01;

endpackage

// File: rtl/ld_str_byte_align.sv
// Byte-lane steering shared by the load and store paths.
// Ports:
//   byte_op  in   1 = byte access, 0 = word access
//   addr_lsb in   bit 0 of the effective address (selects the byte lane)
//   rdata    in   raw cache read word
//   wdata    in   raw store data
//   ld_data  out  load result (zero-extended byte or full word)
//   st_data  out  store word presented to the cache
//   byte_en  out  cache byte-lane enables for the store
module ld_str_byte_align
  import ld_str_mem_unit_pkg::*;
(
  input  logic     byte_op,
  input  logic     addr_lsb,
  input  lc3b_word rdata,
  input  lc3b_word wdata,
  output lc3b_word ld_data,
  output lc3b_word st_data,
  output logic [1:0] byte_en
);

  always_comb begin
    ld_data = rdata;
    st_data = wdata;
    byte_en = BE_WORD;
    if (byte_op) begin
      ld_data = addr_lsb ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
      // Replicate the byte onto both lanes; the enable picks the lane that lands.
      st_data = {wdata[7:0], wdata[7:0]};
      byte_en = addr_lsb ? BE_HI : BE_LO;
    end
  end

endmodule

// File: rtl/ld_str_mem_unit.sv
// Load/store memory unit between the load/store reservation station and the
// data cache. Accepts a level-held read/write request, runs the cache
// handshake until mem_resp, and returns load data with a one-cycle strobe.
// Ports:
//   clk, rst            clock, async active-high reset
//   flush               pipeline squash (blocks acceptance, squashes loads)
//   dmem_read/write     station requests (level-held)
//   byte_op             1 = byte access
//   dmem_addr/wdata     effective address / store data
//   dest_tag            ROB tag of the load
//   req_ack             one-cycle pulse, request latched
//   mem_val/mem_tag     last completed load result and its tag
//   ld_mem_val          one-cycle strobe, mem_val/mem_tag valid
//   st_done             one-cycle strobe, store committed
//   mem_*               data cache interface
//
// state   | meaning
// IDLE    | waiting for a station request
// READ    | cache read outstanding, held until mem_resp
// WRITE   | cache write outstanding, held until mem_resp
// RELEASE | access done, waiting for the station to drop its request
module ld_str_mem_unit
  import ld_str_mem_unit_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int tag_width  = TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic                  byte_op,
  input  logic [data_width-1:0] dmem_addr,
  input  logic [data_width-1:0] dmem_wdata,
  input  logic [tag_width-1:0]  dest_tag,
  output logic                  req_ack,
  output logic [data_width-1:0] mem_val,
  output logic [tag_width-1:0]  mem_tag,
  output logic                  ld_mem_val,
  output logic                  st_done,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [data_width-1:0] mem_address,
  output logic [data_width-1:0] mem_wdata,
  output logic [1:0]            mem_byte_enable,
  input  logic                  mem_resp,
  input  logic [data_width-1:0] mem_rdata
);

  lsu_state_e state_q, state_d;
  lc3b_word addr_q, addr_d;
  lc3b_word wdata_q, wdata_d;
  logic byte_q, byte_d;
  logic [tag_width-1:0] tag_q, tag_d;
  logic squash_q, squash_d;
  lc3b_word mem_val_q, mem_val_d;
  logic [tag_width-1:0] mem_tag_q, mem_tag_d;
  logic ld_mem_val_q, ld_mem_val_d;
  logic st_done_q, st_done_d;
  logic req_ack_q, req_ack_d;

  lc3b_word ld_data;
  lc3b_word st_data;
  logic [1:0] byte_en;

  ld_str_byte_align u_align (
    .byte_op  (byte_q),
    .addr_lsb (addr_q[0]),
    .rdata    (mem_rdata),
    .wdata    (wdata_q),
    .ld_data  (ld_data),
    .st_data  (st_data),
    .byte_en  (byte_en)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    byte_d          = byte_q;
    tag_d           = tag_q;
    squash_d        = squash_q;
    mem_val_d       = mem_val_q;
    mem_tag_d       = mem_tag_q;
    ld_mem_val_d    = 1'b0;
    st_done_d       = 1'b0;
    req_ack_d       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = 2'b00;

    case (state_q)
      IDLE: begin
        squash_d = 1'b0;
        if (!flush) begin
          // Stores win when both requests are raised together.
          if (dmem_write) begin
            addr_d    = dmem_addr;
            wdata_d   = dmem_wdata;
            byte_d    = byte_op;
            req_ack_d = 1'b1;
            state_d   = WRITE;
          end else if (dmem_read) begin
            addr_d    = dmem_addr;
            byte_d    = byte_op;
            tag_d     = dest_tag;
            req_ack_d = 1'b1;
            state_d   = READ;
          end
        end
      end
      READ: begin
        mem_read    = 1'b1;
        mem_address = {addr_q[15:1], 1'b0};
        // The cache has no abort, so a flushed load still runs to mem_resp.
        if (flush) squash_d = 1'b1;
        if (mem_resp) begin
          if (!(squash_q || flush)) begin
            mem_val_d    = ld_data;
            mem_tag_d    = tag_q;
            ld_mem_val_d = 1'b1;
          end
          state_d = RELEASE;
        end
      end
      WRITE: begin
        mem_write       = 1'b1;
        mem_address     = {addr_q[15:1], 1'b0};
        mem_wdata       = st_data;
        mem_byte_enable = byte_en;
        if (mem_resp) begin
          st_done_d = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        // Wait out the level-held request so it is not issued twice.
        if ((!dmem_read && !dmem_write) || flush) begin
          state_d  = IDLE;
          squash_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      byte_q       <= 1'b0;
      tag_q        <= '0;
      squash_q     <= 1'b0;
      mem_val_q    <= '0;
      mem_tag_q    <= '0;
      ld_mem_val_q <= 1'b0;
      st_done_q    <= 1'b0;
      req_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      byte_q       <= byte_d;
      tag_q        <= tag_d;
      squash_q     <= squash_d;
      mem_val_q    <= mem_val_d;
      mem_tag_q    <= mem_tag_d;
      ld_mem_val_q <= ld_mem_val_d;
      st_done_q    <= st_done_d;
      req_ack_q    <= req_ack_d;
    end
  end

  assign req_ack    = req_ack_q;
  assign mem_val    = mem_val_q;
  assign mem_tag    = mem_tag_q;
  assign ld_mem_val = ld_mem_val_q;
  assign st_done    = st_done_q;

endmodule

// File: tb/tb_ld_str_mem_unit.sv
module tb_ld_str_mem_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        dmem_read;
  logic        dmem_write;
  logic        byte_op;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [2:0]  dest_tag;
  logic        req_ack;
  logic [15:0] mem_val;
  logic [2:0]  mem_tag;
  logic        ld_mem_val;
  logic        st_done;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  ld_str_mem_unit dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .dmem_read       (dmem_read),
    .dmem_write      (dmem_write),
    .byte_op         (byte_op),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dest_tag        (dest_tag),
    .req_ack         (req_ack),
    .mem_val         (mem_val),
    .mem_tag         (mem_tag),
    .ld_mem_val      (ld_mem_val),
    .st_done         (st_done),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        is_store;
    logic        is_byte;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [2:0]  tag;
    logic [15:0] rdata;
    int          waits;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic [1:0]  exp_be;
    logic [15:0] exp_val;
  } vec_t;

  vec_t vecs[7];
  logic [15:0] last_val;
  logic [2:0]  last_tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_req();
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    byte_op    = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int held;
    byte_op    = v.is_byte;
    dmem_addr  = v.addr;
    dmem_wdata = v.wdata;
    dest_tag   = v.tag;
    dmem_write = v.is_store;
    dmem_read  = !v.is_store;
    tick();
    chk({v.name, " req_ack"}, req_ack, 1);
    chk({v.name, " mem_address"}, mem_address, v.exp_addr);
    if (v.is_store) begin
      chk({v.name, " mem_wdata"}, mem_wdata, v.exp_wdata);
      chk({v.name, " be"}, mem_byte_enable, v.exp_be);
      chk({v.name, " mem_read off"}, mem_read, 0);
    end
    held = v.is_store ? int'(mem_write) : int'(mem_read);
    for (int i = 0; i < v.waits; i++) begin
      tick();
      held += v.is_store ? int'(mem_write) : int'(mem_read);
      chk({v.name, " req_ack single"}, req_ack, 0);
    end
    chk({v.name, " cycles held"}, held, v.waits + 1);
    mem_resp  = 1'b1;
    mem_rdata = v.rdata;
    tick();
    mem_resp  = 1'b0;
    mem_rdata = 16'h0000;
    if (v.is_store) begin
      chk({v.name, " st_done"}, st_done, 1);
      chk({v.name, " no ld strobe"}, ld_mem_val, 0);
    end else begin
      chk({v.name, " ld_mem_val"}, ld_mem_val, 1);
      last_val = v.exp_val;
      last_tag = v.tag;
    end
    chk({v.name, " mem_val"}, mem_val, last_val);
    chk({v.name, " mem_tag"}, mem_tag, last_tag);
    chk({v.name, " released"}, {mem_read, mem_write}, 0);
    // Request still held: must not be re-issued.
    tick();
    chk({v.name, " strobe one cycle"}, {ld_mem_val, st_done}, 0);
    chk({v.name, " no reissue"}, {mem_read, mem_write, req_ack}, 0);
    drop_req();
    tick();
  endtask

  initial begin
    vecs[0] = '{"ldr_word", 1'b0, 1'b0, 16'h1004, 16'h0000, 3'd5, 16'hBEEF, 2, 16'h1004, 16'h0000, 2'b00, 16'hBEEF};
    vecs[1] = '{"ldb_odd",  1'b0, 1'b1, 16'h2003, 16'h0000, 3'd2, 16'hA55A, 0, 16'h2002, 16'h0000, 2'b00, 16'h00A5};
    vecs[2] = '{"ldb_even", 1'b0, 1'b1, 16'h2002, 16'h0000, 3'd7, 16'hA55A, 1, 16'h2002, 16'h0000, 2'b00, 16'h005A};
    vecs[3] = '{"stb_odd",  1'b1, 1'b1, 16'h3001, 16'h12CD, 3'd0, 16'h0000, 1, 16'h3000, 16'hCDCD, 2'b10, 16'h0000};
    vecs[4] = '{"str_word", 1'b1, 1'b0, 16'h4000, 16'h1234, 3'd0, 16'h0000, 0, 16'h4000, 16'h1234, 2'b11, 16'h0000};
    vecs[5] = '{"stb_even", 1'b1, 1'b1, 16'h4002, 16'h00EE, 3'd0, 16'h0000, 2, 16'h4002, 16'hEEEE, 2'b01, 16'h0000};
    vecs[6] = '{"ldr_odd",  1'b0, 1'b0, 16'h5001, 16'h0000, 3'd3, 16'h7788, 0, 16'h5000, 16'h0000, 2'b00, 16'h7788};

    rst = 1'b1; flush = 1'b0; mem_resp = 1'b0; mem_rdata = 16'h0;
    dmem_addr = 16'h0; dmem_wdata = 16'h0; dest_tag = 3'd0;
    drop_req();
    last_val = 16'h0; last_tag = 3'd0;
    tick();
    chk("reset outputs", {req_ack, ld_mem_val, st_done, mem_read, mem_write,
                          mem_address, mem_wdata, mem_byte_enable}, 0);
    chk("reset mem_val", {mem_tag, mem_val}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Flush one cycle after acceptance: cache access completes, result dropped.
    dmem_read = 1'b1; byte_op = 1'b0; dmem_addr = 16'h6000; dest_tag = 3'd4;
    tick();
    chk("flush accept", mem_read, 1);
    flush = 1'b1; dmem_read = 1'b0;
    tick();
    flush = 1'b0;
    chk("flush mem_read held", mem_read, 1);
    tick();
    chk("flush mem_read held 2", mem_read, 1);
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_resp = 1'b0;
    chk("flush no strobe", ld_mem_val, 0);
    chk("flush mem_val kept", mem_val, last_val);
    chk("flush mem_tag kept", mem_tag, last_tag);
    chk("flush released", mem_read, 0);
    tick();

    // Flush in IDLE blocks acceptance.
    dmem_read = 1'b1; dmem_addr = 16'h7000; dest_tag = 3'd6; flush = 1'b1;
    tick();
    chk("flush blocks ack", {req_ack, mem_read}, 0);
    flush = 1'b0;
    // Next load completes normally: squash must have been cleared.
    tick();
    chk("post flush accept", {req_ack, mem_read}, 2'b11);
    mem_resp = 1'b1; mem_rdata = 16'h0F0F;
    tick();
    mem_resp = 1'b0;
    chk("post flush strobe", ld_mem_val, 1);
    chk("post flush val", mem_val, 16'h0F0F);
    chk("post flush tag", mem_tag, 3'd6);
    drop_req();
    tick();
    tick();

    // Both requests: write first. Then async reset mid-write.
    dmem_read = 1'b1; dmem_write = 1'b1; byte_op = 1'b0;
    dmem_addr = 16'h8004; dmem_wdata = 16'h5555; dest_tag = 3'd1;
    tick();
    chk("both write wins", {mem_write, mem_read}, 2'b10);
    chk("both wdata", mem_wdata, 16'h5555);
    tick();
    chk("both write held", {mem_write, mem_read}, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst outputs", {mem_write, mem_read, mem_address, mem_wdata, mem_byte_enable}, 0);
    chk("async rst mem_val", {mem_tag, mem_val}, 0);
    drop_req();
    tick();
    rst = 1'b0;
    tick();
    chk("idle after rst", {mem_read, mem_write, req_ack}, 0);
    dmem_read = 1'b1; dmem_addr = 16'h9002; dest_tag = 3'd2;
    tick();
    chk("accept after rst", {req_ack, mem_read, mem_address}, {2'b11, 16'h9002});
    drop_req();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
